// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128/192/256 inverse cipher, one round per clock, on-chip key expansion.
// Define AES_DEC_CBC_EN to build with CBC chaining; without it the block runs in ECB mode.
`timescale 1ns/1ps
module aes_decrypt_iter #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [KEY_BITS-1:0] key_in,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic [127:0]        iv_in,
   input  logic [127:0]        in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [127:0]        out_data,
   output logic                out_valid,
   input  logic                out_ready
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam int AW = $clog2(NW);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] b;
      r = 8'h01;
      b = a;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gf_mul(r, b);
         b = gf_mul(b, b);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
   endfunction

   // Byte n of a block sits at [127-8n -: 8]; column c holds bytes 4c..4c+3, row r is byte 4c+r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [7:0]   coef [4];
      logic [7:0]   a [4];
      logic [7:0]   acc;
      logic [127:0] o;
      coef[0] = 8'h0e;
      coef[1] = 8'h0b;
      coef[2] = 8'h0d;
      coef[3] = 8'h09;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[2'((j-r+4)%4)], a[j]);
            o[127-8*(4*c+r) -: 8] = acc;
         end
      end
      return o;
   endfunction

   typedef enum logic [2:0] {NOKEY, KEYEXP, IDLE, RUN, HOLD} state_t;

   state_t          fsm_reg, fsm_next;
   logic            key_load, blk_load;
   logic [31:0]     key_mem [NW];
   logic [127:0]    state_reg;
   logic [3:0]      round_reg;
   logic [AW-1:0]   kx_idx_reg;
   logic [2:0]      kx_mod_reg;
   logic [7:0]      rcon_reg;
   logic [127:0]    out_data_reg;

   logic [3:0]      rk_idx;
   logic [31:0]     rk_word [4];
   logic [127:0]    rk_blk, isr_blk, isb_blk, ark_blk, imc_blk, final_blk;
   logic [31:0]     kx_prev, kx_back, kx_rot, kx_sin, kx_sub, kx_temp, kx_word;

   genvar gi;

   // Round key index: rk[NR] for the initial whitening in IDLE, the live round counter otherwise.
   assign rk_idx = (fsm_reg == RUN) ? round_reg : 4'(NR);
   for (gi = 0; gi < 4; gi++) begin : g_rk
      assign rk_word[gi] = key_mem[AW'({rk_idx, 2'(gi)})];
   end
   assign rk_blk = {rk_word[0], rk_word[1], rk_word[2], rk_word[3]};

   assign isr_blk = inv_shift_rows(state_reg);
   for (gi = 0; gi < 16; gi++) begin : g_isb
      assign isb_blk[8*gi +: 8] = inv_sbox(isr_blk[8*gi +: 8]);
   end
   assign ark_blk = isb_blk ^ rk_blk;
   assign imc_blk = inv_mix_columns(ark_blk);

   assign kx_prev = key_mem[kx_idx_reg - AW'(1)];
   assign kx_back = key_mem[kx_idx_reg - AW'(NK)];
   assign kx_rot  = {kx_prev[23:0], kx_prev[31:24]};
   assign kx_sin  = (kx_mod_reg == 3'd0) ? kx_rot : kx_prev;
   for (gi = 0; gi < 4; gi++) begin : g_kx_sub
      assign kx_sub[8*gi +: 8] = sbox(kx_sin[8*gi +: 8]);
   end

   always_comb begin
      kx_temp = kx_prev;
      if (kx_mod_reg == 3'd0) kx_temp = kx_sub ^ {rcon_reg, 24'h000000};
      else if (NK == 8 && kx_mod_reg == 3'd4) kx_temp = kx_sub;
   end
   assign kx_word = kx_back ^ kx_temp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm_reg <= NOKEY;
      else     fsm_reg <= fsm_next;
   end

   always_comb begin
      fsm_next  = fsm_reg;
      key_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      key_load  = 1'b0;
      blk_load  = 1'b0;
      case (fsm_reg)
         NOKEY: begin
            key_ready = 1'b1;
            if (key_valid) begin
               key_load = 1'b1;
               fsm_next = KEYEXP;
            end
         end
         KEYEXP: begin
            if (kx_idx_reg == AW'(NW-1)) fsm_next = IDLE;
         end
         IDLE: begin
            key_ready = 1'b1;
            in_ready  = 1'b1;
            // A key request pre-empts a pending block.
            if (key_valid) begin
               key_load = 1'b1;
               fsm_next = KEYEXP;
            end else if (in_valid) begin
               blk_load = 1'b1;
               fsm_next = RUN;
            end
         end
         RUN: begin
            if (round_reg == 4'd0) fsm_next = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) fsm_next = IDLE;
         end
         default: fsm_next = NOKEY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (key_load) begin
         for (int j = 0; j < NK; j++) key_mem[AW'(j)] <= key_in[KEY_BITS-1-32*j -: 32];
      end else if (fsm_reg == KEYEXP) begin
         key_mem[kx_idx_reg] <= kx_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= '0;
         round_reg    <= '0;
         kx_idx_reg   <= '0;
         kx_mod_reg   <= '0;
         rcon_reg     <= '0;
         out_data_reg <= '0;
      end else begin
         if (key_load) begin
            kx_idx_reg <= AW'(NK);
            kx_mod_reg <= 3'd0;
            rcon_reg   <= 8'h01;
         end else if (fsm_reg == KEYEXP) begin
            kx_idx_reg <= kx_idx_reg + AW'(1);
            kx_mod_reg <= (kx_mod_reg == 3'(NK-1)) ? 3'd0 : kx_mod_reg + 3'd1;
            if (kx_mod_reg == 3'd0) rcon_reg <= xtime(rcon_reg);
         end
         if (blk_load) begin
            state_reg <= in_data ^ rk_blk;
            round_reg <= 4'(NR-1);
         end else if (fsm_reg == RUN) begin
            if (round_reg != 4'd0) begin
               state_reg <= imc_blk;
               round_reg <= round_reg - 4'd1;
            end else begin
               out_data_reg <= final_blk;
            end
         end
      end
   end

`ifdef AES_DEC_CBC_EN
   logic [127:0] chain_reg, capt_reg;

   // The ciphertext of the block in flight becomes the chain value once its plaintext is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_reg <= '0;
         capt_reg  <= '0;
      end else begin
         if (key_load) chain_reg <= iv_in;
         else if (out_valid && out_ready) chain_reg <= capt_reg;
         if (blk_load) capt_reg <= in_data;
      end
   end
   assign final_blk = ark_blk ^ chain_reg;
`else
   logic unused_iv;
   assign unused_iv = ^iv_in;
   assign final_blk = ark_blk;
`endif

   assign out_data = out_data_reg;

endmodule
